// File: rtl/mmio_slot_bridge.sv
// Bridges single-cycle processor MMIO requests onto 64 register slots.
// A request takes one ACCESS cycle and then one RESP cycle; malformed requests are counted.
module mmio_slot_bridge #(
    parameter logic [7:0] BASE_PREFIX = 8'hC0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          io_addr_strobe,
    input  logic          io_read_strobe,
    input  logic          io_write_strobe,
    input  logic [31:0]   io_address,
    input  logic [3:0]    io_byte_enable,
    input  logic [31:0]   io_write_data,
    output logic [31:0]   io_read_data,
    output logic          io_ready,
    output logic          bus_err,
    output logic [7:0]    err_count,
    output logic [63:0]   slot_cs_array,
    output logic          slot_read,
    output logic          slot_write,
    output logic [4:0]    slot_reg_addr,
    output logic [31:0]   slot_wr_data,
    input  logic [2047:0] slot_rd_data_array
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    logic [5:0]  r_slot;
    logic [4:0]  r_reg_addr;
    logic [31:0] r_wr_data;
    logic        r_is_read;
    logic        r_err;
    logic [31:0] r_rbuf;
    logic        r_ready;
    logic        r_bus_err;
    logic [7:0]  r_err_count;
    logic [63:0] r_cs;
    logic        r_slot_read;
    logic        r_slot_write;

    logic        w_req_err;
    logic [10:0] w_sel_base;
    logic [31:0] w_sel_data;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic        w_unused_addr;

    assign w_unused_addr = ^{io_address[23:13], io_address[1:0]};

    assign w_req_err = (io_address[31:24] != BASE_PREFIX)
                     | ~(io_read_strobe ^ io_write_strobe)
                     | (io_write_strobe & (io_byte_enable != 4'hF));

    assign w_sel_base = {r_slot, 5'd0};
    assign w_sel_data = slot_rd_data_array[w_sel_base +: 32];

    // A response-cycle error and a strobe arriving mid-transaction land on the same edge.
    assign w_err_inc = {1'b0, (r_state == ACCESS) & r_err}
                     + {1'b0, io_addr_strobe & (r_state != IDLE)};
    assign w_err_sum = {1'b0, r_err_count} + {7'd0, w_err_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_slot       <= '0;
            r_reg_addr   <= '0;
            r_wr_data    <= '0;
            r_is_read    <= 1'b0;
            r_err        <= 1'b0;
            r_rbuf       <= '0;
            r_ready      <= 1'b0;
            r_bus_err    <= 1'b0;
            r_err_count  <= '0;
            r_cs         <= '0;
            r_slot_read  <= 1'b0;
            r_slot_write <= 1'b0;
        end else begin
            r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            case (r_state)
                IDLE: begin
                    r_ready   <= 1'b0;
                    r_bus_err <= 1'b0;
                    r_rbuf    <= '0;
                    if (io_addr_strobe) begin
                        r_slot       <= io_address[12:7];
                        r_reg_addr   <= io_address[6:2];
                        r_wr_data    <= io_write_data;
                        r_is_read    <= io_read_strobe;
                        r_err        <= w_req_err;
                        r_cs         <= w_req_err ? '0 : (64'd1 << io_address[12:7]);
                        r_slot_read  <= ~w_req_err & io_read_strobe;
                        r_slot_write <= ~w_req_err & io_write_strobe;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_cs         <= '0;
                    r_slot_read  <= 1'b0;
                    r_slot_write <= 1'b0;
                    r_rbuf       <= (~r_err & r_is_read) ? w_sel_data : '0;
                    r_ready      <= 1'b1;
                    r_bus_err    <= r_err;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_ready   <= 1'b0;
                    r_bus_err <= 1'b0;
                    r_rbuf    <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_read_data  = r_rbuf;
    assign io_ready      = r_ready;
    assign bus_err       = r_bus_err;
    assign err_count     = r_err_count;
    assign slot_cs_array = r_cs;
    assign slot_read     = r_slot_read;
    assign slot_write    = r_slot_write;
    assign slot_reg_addr = r_reg_addr;
    assign slot_wr_data  = r_wr_data;

endmodule

// File: doc/mmio_slot_bridge.md
MMIO_SLOT_BRIDGE -- requirements
Module: mmio_slot_bridge

Interface
REQ-001 Parameter: BASE_PREFIX, default 8'hC0, required value of io_address[31:24] for a valid access.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 io_addr_strobe  input  1  processor request strobe, single-cycle pulse.
REQ-005 io_read_strobe  input  1  read qualifier, valid with io_addr_strobe.
REQ-006 io_write_strobe  input  1  write qualifier, valid with io_addr_strobe.
REQ-007 io_address  input  32  byte address.
REQ-008 io_byte_enable  input  4  byte lanes.
REQ-009 io_write_data  input  32  write data.
REQ-010 io_read_data  output  32  read response data, valid when io_ready=1.
REQ-011 io_ready  output  1  one-cycle completion pulse.
REQ-012 bus_err  output  1  error flag, asserted only with io_ready.
REQ-013 err_count  output  8  saturating error/protocol-violation counter.
REQ-014 slot_cs_array  output  64  one-hot slot select.
REQ-015 slot_read  output  1  slot read strobe.
REQ-016 slot_write  output  1  slot write strobe.
REQ-017 slot_reg_addr  output  5  register index within slot.
REQ-018 slot_wr_data  output  32  slot write data.
REQ-019 slot_rd_data_array  input  2048  slot n read data at bits [32n+31:32n].

Function
REQ-020 Address decode: slot = io_address[12:7], register = io_address[6:2]; io_address[23:13] and [1:0] are ignored.
REQ-021 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-022 IDLE: on io_addr_strobe=1, capture address, byte enables, write data and operation type, then go to ACCESS; otherwise stay in IDLE.
REQ-023 A request is erroneous if io_address[31:24]!=BASE_PREFIX, if io_read_strobe and io_write_strobe are both 0 or both 1, or if it is a write with io_byte_enable!=4'hF; the error status is captured in IDLE.
REQ-024 ACCESS (exactly one cycle), valid request: slot_cs_array = one-hot(slot); slot_read or slot_write = 1 according to op; slot_reg_addr and slot_wr_data = captured values.
REQ-025 ACCESS, read: register slot_rd_data_array[selected slot] into the response buffer at the end of the ACCESS cycle.
REQ-026 ACCESS, erroneous request: slot_cs_array=0 and slot_read=slot_write=0; response buffer loaded with 0.
REQ-027 Outside ACCESS: slot_cs_array=0 and slot_read=slot_write=0; slot_reg_addr and slot_wr_data hold their last captured values.
REQ-028 RESP: io_ready=1 for one cycle; io_read_data = buffer for a valid read, otherwise 0; bus_err = captured error status; next state IDLE.
REQ-029 io_read_data=0, io_ready=0 and bus_err=0 in every cycle outside RESP.
REQ-030 Latency: strobe sampled at cycle N -> slot access at N+1 -> io_ready at N+2; a new request is accepted at N+3 at the earliest.
REQ-031 io_addr_strobe=1 while in ACCESS or RESP: request ignored, no slot activity, err_count incremented.
REQ-032 err_count increments by 1 in the RESP cycle of each erroneous request; it saturates at 8'hFF and never wraps.
REQ-033 A RESP-cycle error and an ignored strobe in the same cycle increment err_count by 2, saturating.

Reset
REQ-034 On reset assertion, immediately: state IDLE, all outputs 0, response buffer 0, captured registers 0, err_count 0.
REQ-035 Reset during ACCESS or RESP aborts the transaction; no io_ready pulse is issued for it after reset is released.

Verification
REQ-036 Write 0xC000_0108, data 0x0000_0003, byte enables 4'hF at cycle N -> at N+1 slot_cs_array=64'h4, slot_write=1, slot_reg_addr=2, slot_wr_data=3; at N+2 io_ready=1, bus_err=0.
REQ-037 Read 0xC000_0100 with slot 2 data 0x1234_5678 -> at N+1 slot_read=1, slot_cs_array=64'h4; at N+2 io_ready=1, io_read_data=0x1234_5678.
REQ-038 Read 0x8000_0000 -> no slot_cs_array bit asserted; at N+2 io_ready=1, bus_err=1, io_read_data=0, err_count=1.
REQ-039 Write with byte enables 4'h3, and a strobe with both read and write qualifiers -> each: bus_err=1 and no slot strobe; err_count +1 each.
REQ-040 Strobe repeated at N+1 -> only one transaction, err_count +1; 300 error requests -> err_count=8'hFF.
REQ-041 Reset asserted at N+1 of a read -> all outputs 0 immediately; no io_ready after release; the next read completes normally.
